pipe_perf_monitor: RTL and testbench

//   Synthesizable performance monitor that sits downstream of the pipelined CPU core.
//   - Counts run cycles, qualified hazard stalls, pipeline flushes and PC-advance events.
//   - Enforces a run-window cycle limit and raises a halt flag when the limit is reached.
//   - Exposes all counters through a one-request/one-ack register readout port.

---
 rtl/pipe_perf_pkg.sv | 5 +
 rtl/perf_counter.sv | 21 ++
 rtl/pipe_perf_monitor.sv | 65 ++++++
 tb/tb_pipe_perf_monitor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_perf_pkg.sv
// pipe_perf_pkg: run-window FSM states and counter select encodings
package pipe_perf_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   typedef enum logic [1:0] {SEL_CYC, SEL_STL, SEL_FLS, SEL_PCA} sel_t;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: clearable event counter; wraps by default, saturates at all-ones when PERF_SAT_EN is defined
module perf_counter
   import pipe_perf_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) cnt <= '0;
      else if (clr) cnt <= '0;
`ifdef PERF_SAT_EN
      else if (inc && !(&cnt)) cnt <= cnt + W'(1);
`else
      else if (inc) cnt <= cnt + W'(1);
`endif
endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: run-window cycle/stall/flush/pc-advance counters with halt limit and register readout
// Counter overflow behaviour selected by PERF_SAT_EN (saturate) or its absence (wrap).
module pipe_perf_monitor
   import pipe_perf_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 60
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             jump_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic [31:0]      pc_i,
   input  logic             rd_req_i,
   input  logic [1:0]       rd_sel_i,
   output logic             rd_ack_o,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             running_o,
   output logic             halt_o
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);
   state_t           state;
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0]       inc;
   logic             act, clr, hit;
   // leaving RUN on start_i=0 freezes counters on that same edge
   assign act = (state == RUN) && start_i;
   assign clr = (state == IDLE) && start_i;
   assign inc = {4{act}} & {pc_i != pc_q, flush_i, stall_i & ~jump_i & ~branch_i, 1'b1};
   assign hit = (MAX_CYCLES != 0) && (cnt[SEL_CYC] + CNT_W'(1) == LIMIT);
   assign running_o = (state == RUN);
   assign halt_o    = (state == HALT);
   for (genvar g = 0; g < 4; g++) begin : g_cnt
      perf_counter #(.W(CNT_W)) u_cnt (
         .clk_i(clk_i),
         .rst_i(rst_i),
         .clr  (clr),
         .inc  (inc[g]),
         .cnt  (cnt[g])
      );
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= IDLE;
      else
         case (state)
            IDLE:    state <= start_i ? RUN : IDLE;
            RUN:     state <= !start_i ? IDLE : hit ? HALT : RUN;
            HALT:    state <= start_i ? HALT : IDLE;
            default: state <= IDLE;
         endcase
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         pc_q      <= '0;
         rd_ack_o  <= 1'b0;
         rd_data_o <= '0;
      end else begin
         pc_q     <= pc_i;
         rd_ack_o <= rd_req_i;
         if (rd_req_i) rd_data_o <= cnt[rd_sel_i];
      end
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: randomized and directed checks of two monitor instances (32b/limit 60, 4b/unlimited)
module tb_pipe_perf_monitor;
   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0, stall_i = 1'b0, jump_i = 1'b0, branch_i = 1'b0, flush_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        rd_req_i = 1'b0;
   logic [1:0]  rd_sel_i = '0;
   logic        rd_ack, running, halt, rd_ack4, running4, halt4;
   logic [31:0] rd_data;
   logic [3:0]  rd_data4;
   int          checks = 0, errors = 0;
   logic [31:0] mc [2][4];
   logic [31:0] md [2];
   bit          mr [2], mh [2], ma;
   logic [31:0] mpc;

   always #5 clk = ~clk;

   pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(60)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .jump_i(jump_i),
      .branch_i(branch_i), .flush_i(flush_i), .pc_i(pc_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
      .rd_ack_o(rd_ack), .rd_data_o(rd_data), .running_o(running), .halt_o(halt));

   pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut4 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .jump_i(jump_i),
      .branch_i(branch_i), .flush_i(flush_i), .pc_i(pc_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
      .rd_ack_o(rd_ack4), .rd_data_o(rd_data4), .running_o(running4), .halt_o(halt4));

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) mc[k][j] = '0;
         md[k] = '0; mr[k] = 0; mh[k] = 0;
      end
      ma = 0; mpc = '0;
   endtask

   // advance the reference by one clock edge, then sample 1 time unit later
   task automatic step();
      logic [3:0]  ev;
      logic [31:0] mask;
      int          lim;
      ev = {pc_i != mpc, flush_i, stall_i & ~jump_i & ~branch_i, 1'b1};
      for (int k = 0; k < 2; k++) begin
         mask = (k == 0) ? 32'hFFFF_FFFF : 32'hF;
         lim  = (k == 0) ? 60 : 0;
         if (rd_req_i) md[k] = mc[k][rd_sel_i];
         if (mr[k]) begin
            if (!start_i) mr[k] = 0;
            else begin
               for (int j = 0; j < 4; j++)
                  if (ev[j])
`ifdef PERF_SAT_EN
                     mc[k][j] = (mc[k][j] == mask) ? mask : mc[k][j] + 1;
`else
                     mc[k][j] = (mc[k][j] + 1) & mask;
`endif
               if (lim != 0 && mc[k][0] == 32'(lim)) begin mr[k] = 0; mh[k] = 1; end
            end
         end else if (mh[k]) begin
            if (!start_i) mh[k] = 0;
         end else if (start_i) begin
            mr[k] = 1;
            for (int j = 0; j < 4; j++) mc[k][j] = '0;
         end
      end
      ma = rd_req_i; mpc = pc_i;
      @(posedge clk); #1;
   endtask

   task automatic do_read(input int j);
      rd_req_i = 1'b1; rd_sel_i = 2'(j);
      step();
      rd_req_i = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({rd_ack, rd_data, running, halt, rd_ack4, rd_data4, running4, halt4} !== '0) begin
         errors++;
         $display("FAIL reset: ack=%b data=%0d run=%b halt=%b, required all 0", rd_ack, rd_data, running, halt);
      end
      @(posedge clk); #1;
      rst_i = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      int exp [4] = '{10, 0, 0, 10};
      start_i = 0; step();
      start_i = 1; pc_i += 4; step();
      for (int i = 0; i < 10; i++) begin pc_i += 4; step(); end
      start_i = 0; step();
      for (int j = 0; j < 4; j++) begin
         do_read(j);
         checks++;
         if (rd_ack !== 1'b1 || rd_data !== 32'(exp[j]) || rd_data !== md[0]) begin
            errors++;
            $display("FAIL basic sel%0d: ack=%b data=%0d, required ack=1 data=%0d", j, rd_ack, rd_data, exp[j]);
         end
      end
   endtask

   task automatic test_stall_flush();
      int exp [4] = '{6, 2, 2, 0};
      start_i = 0; step();
      start_i = 1; step();
      stall_i = 1; jump_i = 1; step();
      jump_i = 0; step(); step();
      stall_i = 0; flush_i = 1; step();
      flush_i = 0; step();
      flush_i = 1; step();
      flush_i = 0; start_i = 0; step();
      for (int j = 0; j < 4; j++) begin
         do_read(j);
         checks++;
         if (rd_ack !== 1'b1 || rd_data !== 32'(exp[j]) || rd_data !== md[0]) begin
            errors++;
            $display("FAIL stall_flush sel%0d: ack=%b data=%0d, required ack=1 data=%0d", j, rd_ack, rd_data, exp[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d1;
      start_i = 0; step();
      start_i = 1; step();
      stall_i = 1; step(); step(); step();
      rd_req_i = 1; rd_sel_i = 2'd1; step();
      d1 = rd_data;
      checks++;
      if (rd_ack !== 1'b1 || rd_data !== 32'd3) begin
         errors++;
         $display("FAIL b2b first: ack=%b data=%0d, required ack=1 data=3", rd_ack, rd_data);
      end
      step();
      checks++;
      if (rd_ack !== 1'b1 || rd_data !== d1 + 1 || rd_data !== md[0]) begin
         errors++;
         $display("FAIL b2b second: ack=%b data=%0d, required ack=1 data=%0d", rd_ack, rd_data, md[0]);
      end
      rd_req_i = 0; stall_i = 0;
      step();
      checks++;
      if (rd_ack !== 1'b0 || rd_data !== md[0]) begin
         errors++;
         $display("FAIL b2b hold: ack=%b data=%0d, required ack=0 data=%0d", rd_ack, rd_data, md[0]);
      end
   endtask

   task automatic test_halt();
      start_i = 0; step();
      start_i = 1; step();
      for (int i = 0; i < 70; i++) begin
         {stall_i, jump_i, branch_i, flush_i} = 4'($urandom);
         pc_i = ($urandom_range(0, 3) == 0) ? pc_i : pc_i + 4;
         step();
         checks++;
         if (halt !== (i >= 59) || running !== (i < 59) || halt !== mh[0]) begin
            errors++;
            $display("FAIL halt cyc%0d: halt=%b run=%b, required halt=%b", i, halt, running, i >= 59);
         end
      end
      {stall_i, jump_i, branch_i, flush_i} = '0;
      do_read(0);
      checks++;
      if (rd_data !== 32'd60) begin
         errors++;
         $display("FAIL halt cycles: data=%0d, required 60", rd_data);
      end
      for (int j = 1; j < 4; j++) begin
         do_read(j);
         checks++;
         if (rd_data !== md[0]) begin
            errors++;
            $display("FAIL halt sel%0d: data=%0d, required %0d", j, rd_data, md[0]);
         end
      end
      start_i = 0; step();
      checks++;
      if (halt !== 1'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL halt exit: halt=%b run=%b, required 0 0", halt, running);
      end
      start_i = 1; step();
      do_read(0);
      checks++;
      if (running !== 1'b1 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL halt rerun: run=%b cycles=%0d, required run=1 cycles=0", running, rd_data);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp4;
`ifdef PERF_SAT_EN
      exp4 = 4'd15;
`else
      exp4 = 4'd4;
`endif
      start_i = 0; step();
      start_i = 1; step();
      for (int i = 0; i < 20; i++) step();
      start_i = 0; step();
      do_read(0);
      checks++;
      if (rd_data4 !== exp4 || rd_data4 !== md[1][3:0] || rd_data !== 32'd20) begin
         errors++;
         $display("FAIL wrap: data4=%0d data=%0d, required data4=%0d data=20", rd_data4, rd_data, exp4);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         start_i  = ($urandom_range(0, 19) != 0);
         {stall_i, jump_i, branch_i, flush_i} = 4'($urandom);
         pc_i     = ($urandom_range(0, 2) == 0) ? pc_i : pc_i + 4;
         rd_req_i = $urandom_range(0, 1);
         rd_sel_i = 2'($urandom);
         step();
         checks++;
         if (rd_ack !== ma || rd_data !== md[0] || running !== mr[0] || halt !== mh[0]) begin
            errors++;
            $display("FAIL random32 cyc%0d: ack=%b data=%0d run=%b halt=%b, required %b %0d %b %b",
                     i, rd_ack, rd_data, running, halt, ma, md[0], mr[0], mh[0]);
         end
         checks++;
         if (rd_ack4 !== ma || rd_data4 !== md[1][3:0] || running4 !== mr[1] || halt4 !== 1'b0) begin
            errors++;
            $display("FAIL random4 cyc%0d: ack=%b data=%0d run=%b halt=%b, required %b %0d %b 0",
                     i, rd_ack4, rd_data4, running4, halt4, ma, md[1][3:0], mr[1]);
         end
      end
      {stall_i, jump_i, branch_i, flush_i, rd_req_i} = '0;
   endtask

   task automatic test_reset_mid();
      start_i = 0; step();
      start_i = 1; step();
      for (int i = 0; i < 5; i++) begin pc_i += 4; step(); end
      rd_req_i = 1; rd_sel_i = 2'd0; step();
      rd_req_i = 1;
      #2 rst_i = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({rd_ack, rd_data, running, halt, rd_ack4, rd_data4, running4, halt4} !== '0) begin
         errors++;
         $display("FAIL reset_mid: ack=%b data=%0d run=%b halt=%b, required all 0", rd_ack, rd_data, running, halt);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_ack !== 1'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid held: ack=%b run=%b, required 0 0", rd_ack, running);
      end
      rd_req_i = 0; start_i = 0;
      rst_i = 1'b1;
      step();
      checks++;
      if (rd_ack !== 1'b0 || running !== 1'b0 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid after: ack=%b run=%b data=%0d, required 0 0 0", rd_ack, running, rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_flush();
      test_back_to_back();
      test_halt();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
